// File: rtl/clock_switch_requester.sv
// Requests a select change from the glitchless clock switcher, waits SETTLE_CYCLES, then responds.
// Optional macro CLOCK_SWITCH_REQUESTER_SKIP_SAME_EN: a request equal to cur_sel responds without switching.
module clock_switch_requester #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_val,
  output logic       req_rdy,
  input  logic [1:0] req_msg,
  output logic       switch_val,
  input  logic       switch_rdy,
  output logic [1:0] switch_msg,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic [1:0] resp_msg,
  output logic [1:0] cur_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0]    SEL_NOMINAL = 2'b10;
  localparam logic [CW-1:0] CNT_LOAD    = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);

  state_t        r_state;
  logic [1:0]    r_pending;
  logic [1:0]    r_cur_sel;
  logic [CW-1:0] r_cnt;

  logic          r_req_rdy;
  logic          r_switch_val;
  logic [1:0]    r_switch_msg;
  logic          r_resp_val;
  logic [1:0]    r_resp_msg;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [1:0]    w_pending_nxt;
  logic [1:0]    w_cur_sel_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Next-state and next-register computation for the request/switch/settle/response sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_cur_sel_nxt = r_cur_sel;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_val && r_req_rdy) begin
          w_pending_nxt = req_msg;
`ifdef CLOCK_SWITCH_REQUESTER_SKIP_SAME_EN
          if (req_msg == r_cur_sel) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
`else
          w_state_nxt = ST_ISSUE;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (switch_rdy) begin
          w_cur_sel_nxt = r_pending;
          w_cnt_nxt     = CNT_LOAD;
          if (SETTLE_CYCLES == 0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_SETTLE: begin
        // Exiting on <=1 keeps the counter from ever wrapping through zero
        if (r_cnt <= CNT_ONE) begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_RESP: begin
        if (resp_rdy) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and outputs registered from the next-state decode
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pending    <= SEL_NOMINAL;
      r_cur_sel    <= SEL_NOMINAL;
      r_cnt        <= CNT_ZERO;
      r_req_rdy    <= 1'b1;
      r_switch_val <= 1'b0;
      r_switch_msg <= SEL_NOMINAL;
      r_resp_val   <= 1'b0;
      r_resp_msg   <= SEL_NOMINAL;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= w_pending_nxt;
      r_cur_sel    <= w_cur_sel_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_rdy    <= (w_state_nxt == ST_IDLE);
      r_switch_val <= (w_state_nxt == ST_ISSUE);
      r_switch_msg <= (w_state_nxt == ST_ISSUE) ? w_pending_nxt : w_cur_sel_nxt;
      r_resp_val   <= (w_state_nxt == ST_RESP);
      r_resp_msg   <= w_cur_sel_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign req_rdy    = r_req_rdy;
  assign switch_val = r_switch_val;
  assign switch_msg = r_switch_msg;
  assign resp_val   = r_resp_val;
  assign resp_msg   = r_resp_msg;
  assign cur_sel    = r_cur_sel;
  assign busy       = r_busy;

endmodule

// File: tb/tb_clock_switch_requester.sv
// Randomized self-checking bench for clock_switch_requester; expectations come from cycle-count formulas.
module tb_clock_switch_requester;

  localparam int S = 4;
`ifdef CLOCK_SWITCH_REQUESTER_SKIP_SAME_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       req_val;
  logic       req_rdy;
  logic [1:0] req_msg;
  logic       switch_val;
  logic       switch_rdy;
  logic [1:0] switch_msg;
  logic       resp_val;
  logic       resp_rdy;
  logic [1:0] resp_msg;
  logic [1:0] cur_sel;
  logic       busy;

  int         checks;
  int         errors;
  logic [1:0] model_sel;

  typedef struct {
    logic       start_rdy;
    int         sw_first;
    int         sw_cnt;
    int         resp_first;
    int         resp_cnt;
    int         done;
    int         bad;
    logic [1:0] cur_end;
  } txn_obs_t;

  clock_switch_requester #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_msg    (req_msg),
    .switch_val (switch_val),
    .switch_rdy (switch_rdy),
    .switch_msg (switch_msg),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_msg   (resp_msg),
    .cur_sel    (cur_sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected timing from the request-fire cycle (cycle 0)
  function automatic int exp_sw_cnt(bit same, int ns);
    return (same && SKIP) ? 0 : ns + 1;
  endfunction
  function automatic int exp_resp_first(bit same, int ns);
    return (same && SKIP) ? 1 : S + 2 + ns;
  endfunction
  function automatic int exp_done(bit same, int ns, int nr);
    return (same && SKIP) ? nr + 2 : S + 3 + ns + nr;
  endfunction

  // Drives one request from a negedge where req_rdy is expected high and records what it observes
  task automatic run_txn(input logic [1:0] msg, input int ns, input int nr,
                         input logic [1:0] old_sel, output txn_obs_t o);
    bit fired;
    fired        = 1'b0;
    o.start_rdy  = req_rdy;
    o.sw_first   = 0;
    o.sw_cnt     = 0;
    o.resp_first = 0;
    o.resp_cnt   = 0;
    o.done       = 0;
    o.bad        = 0;
    o.cur_end    = 2'b00;
    req_val    = 1'b1;
    req_msg    = msg;
    switch_rdy = 1'($urandom);
    resp_rdy   = 1'($urandom);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (switch_val) begin
        o.sw_cnt++;
        if (o.sw_first == 0) o.sw_first = c;
        if (switch_msg !== msg) o.bad++;
      end else if (switch_msg !== cur_sel) o.bad++;
      if (resp_val) begin
        o.resp_cnt++;
        if (o.resp_first == 0) o.resp_first = c;
        if (resp_msg !== msg) o.bad++;
      end else if (resp_msg !== cur_sel) o.bad++;
      if (!fired && cur_sel !== old_sel) o.bad++;
      if (req_rdy === 1'b1) begin
        o.done    = c;
        o.cur_end = cur_sel;
        if (busy !== 1'b0) o.bad++;
        break;
      end
      if (busy !== 1'b1) o.bad++;
      req_val    = resp_val ? 1'b1 : 1'($urandom);
      req_msg    = 2'($urandom);
      switch_rdy = switch_val ? (o.sw_cnt > ns) : 1'($urandom);
      resp_rdy   = resp_val ? (o.resp_cnt > nr) : 1'($urandom);
      if (switch_val && switch_rdy) fired = 1'b1;
    end
    req_val = 1'b0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    req_val    = 1'b0;
    req_msg    = 2'b00;
    switch_rdy = 1'b0;
    resp_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cur_sel, req_rdy, switch_val, resp_val, busy} !== {2'b10, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got cur_sel=%b rdy=%b sval=%b rval=%b busy=%b, want 10 1 0 0 0",
               cur_sel, req_rdy, switch_val, resp_val, busy);
    end
    checks++;
    if ({switch_msg, resp_msg} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_msgs: got switch_msg=%b resp_msg=%b, want 10 10", switch_msg, resp_msg);
    end
    reset_n   = 1'b1;
    model_sel = 2'b10;
  endtask

  task automatic test_basic();
    txn_obs_t o;
    run_txn(2'b00, 0, 0, model_sel, o);
    checks++;
    if (o.start_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_start_rdy: got %b want 1", o.start_rdy);
    end
    checks++;
    if (o.sw_first != 1 || o.sw_cnt != 1) begin
      errors++; $display("FAIL basic_switch: got first=%0d cnt=%0d want 1 1", o.sw_first, o.sw_cnt);
    end
    checks++;
    if (o.resp_first != S + 2 || o.done != S + 3) begin
      errors++;
      $display("FAIL basic_timing: got resp=%0d done=%0d want %0d %0d", o.resp_first, o.done, S + 2, S + 3);
    end
    checks++;
    if (o.bad != 0 || o.cur_end !== 2'b00) begin
      errors++; $display("FAIL basic_integrity: got bad=%0d cur_sel=%b want 0 00", o.bad, o.cur_end);
    end
    model_sel = 2'b00;
  endtask

  task automatic test_switch_stall();
    txn_obs_t o;
    run_txn(2'b01, 3, 0, model_sel, o);
    checks++;
    if (o.sw_cnt != 4) begin
      errors++; $display("FAIL stall_switch_cnt: got %0d want 4", o.sw_cnt);
    end
    checks++;
    if (o.resp_first != S + 5) begin
      errors++; $display("FAIL stall_resp_cycle: got %0d want %0d", o.resp_first, S + 5);
    end
    checks++;
    if (o.bad != 0 || o.cur_end !== 2'b01) begin
      errors++; $display("FAIL stall_integrity: got bad=%0d cur_sel=%b want 0 01", o.bad, o.cur_end);
    end
    model_sel = 2'b01;
  endtask

  task automatic test_resp_stall();
    txn_obs_t o;
    run_txn(2'b11, 0, 5, model_sel, o);
    checks++;
    if (o.resp_cnt != 6) begin
      errors++; $display("FAIL resp_stall_cnt: got %0d want 6", o.resp_cnt);
    end
    checks++;
    if (o.done != S + 8) begin
      errors++; $display("FAIL resp_stall_done: got %0d want %0d", o.done, S + 8);
    end
    checks++;
    if (o.bad != 0 || o.cur_end !== 2'b11) begin
      errors++; $display("FAIL resp_stall_integrity: got bad=%0d cur_sel=%b want 0 11", o.bad, o.cur_end);
    end
    model_sel = 2'b11;
  endtask

  task automatic test_reset_mid();
    int rv;
    rv         = 0;
    req_val    = 1'b1;
    req_msg    = 2'b01;
    switch_rdy = 1'b1;
    resp_rdy   = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    repeat (S - 1) @(negedge clk);
    checks++;
    if (cur_sel !== 2'b01 || busy !== 1'b1 || resp_val !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_reset: got cur_sel=%b busy=%b rval=%b want 01 1 0", cur_sel, busy, resp_val);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cur_sel, req_rdy, busy, resp_val, switch_val} !== {2'b10, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state: got cur_sel=%b rdy=%b busy=%b rval=%b sval=%b want 10 1 0 0 0",
               cur_sel, req_rdy, busy, resp_val, switch_val);
    end
    reset_n = 1'b1;
    repeat (S + 4) begin
      @(negedge clk);
      if (resp_val !== 1'b0 || busy !== 1'b0) rv++;
    end
    checks++;
    if (rv != 0) begin
      errors++; $display("FAIL mid_no_resp: got %0d active cycles want 0", rv);
    end
    model_sel = 2'b10;
  endtask

  task automatic test_same_select();
    txn_obs_t o;
    run_txn(2'b10, 0, 0, model_sel, o);
    checks++;
    if (o.sw_cnt != exp_sw_cnt(1'b1, 0)) begin
      errors++; $display("FAIL same_switch_cnt: got %0d want %0d", o.sw_cnt, exp_sw_cnt(1'b1, 0));
    end
    checks++;
    if (o.resp_first != exp_resp_first(1'b1, 0) || o.done != exp_done(1'b1, 0, 0)) begin
      errors++;
      $display("FAIL same_timing: got resp=%0d done=%0d want %0d %0d",
               o.resp_first, o.done, exp_resp_first(1'b1, 0), exp_done(1'b1, 0, 0));
    end
    checks++;
    if (o.bad != 0 || o.cur_end !== 2'b10) begin
      errors++; $display("FAIL same_integrity: got bad=%0d cur_sel=%b want 0 10", o.bad, o.cur_end);
    end
  endtask

  task automatic test_back_to_back();
    txn_obs_t o;
    logic [1:0] m;
    for (int i = 0; i < 4; i++) begin
      m = (model_sel == 2'b00) ? 2'b01 : 2'b00;
      run_txn(m, 0, 0, model_sel, o);
      checks++;
      if (o.done != S + 3 || o.bad != 0) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got done=%0d bad=%0d want %0d 0", i, o.done, o.bad, S + 3);
      end
      model_sel = m;
    end
  endtask

  task automatic test_random();
    txn_obs_t o;
    logic [1:0] m;
    int ns, nr;
    bit same;
    for (int i = 0; i < 24; i++) begin
      m    = 2'($urandom_range(0, 3));
      ns   = $urandom_range(0, 3);
      nr   = $urandom_range(0, 3);
      same = (m == model_sel);
      run_txn(m, ns, nr, model_sel, o);
      checks++;
      if (o.sw_cnt != exp_sw_cnt(same, ns) || o.resp_first != exp_resp_first(same, ns) ||
          o.resp_cnt != nr + 1 || o.done != exp_done(same, ns, nr)) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got sw=%0d resp=%0d rcnt=%0d done=%0d want %0d %0d %0d %0d",
                 i, o.sw_cnt, o.resp_first, o.resp_cnt, o.done,
                 exp_sw_cnt(same, ns), exp_resp_first(same, ns), nr + 1, exp_done(same, ns, nr));
      end
      checks++;
      if (o.bad != 0 || o.cur_end !== m) begin
        errors++; $display("FAIL rand_integrity[%0d]: got bad=%0d cur_sel=%b want 0 %b", i, o.bad, o.cur_end, m);
      end
      model_sel = m;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_switch_stall();
    test_resp_stall();
    test_reset_mid();
    test_reset();
    test_same_select();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
